// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if
//   Groups the board-side controls and the counter-side signals of the
//   counter sequencer.
//   master : the sequencer (reads buttons/mode/max_in/count, drives cnt_*/state)
//   slave  : the environment (board inputs plus the counter instance)
//   Signals:
//     start_btn, stop_btn, clear_btn, dir_btn, load_max : debounced button levels
//     mode          : 0 = wrap, 1 = bounce
//     max_in[7:0]   : candidate maximum
//     count[7:0]    : counter value fed back
//     cnt_pause     : counter pause
//     cnt_direction : counter direction, 1 = up
//     cnt_maximum   : counter maximum
//     cnt_rst       : active-high one-cycle clear pulse
//     state[1:0]    : sequencer FSM state
interface counter_sequencer_if;
    logic       start_btn;
    logic       stop_btn;
    logic       clear_btn;
    logic       dir_btn;
    logic       load_max;
    logic       mode;
    logic [7:0] max_in;
    logic [7:0] count;
    logic       cnt_pause;
    logic       cnt_direction;
    logic [7:0] cnt_maximum;
    logic       cnt_rst;
    logic [1:0] state;

    modport master (
        input  start_btn, stop_btn, clear_btn, dir_btn, load_max, mode, max_in, count,
        output cnt_pause, cnt_direction, cnt_maximum, cnt_rst, state
    );

    modport slave (
        output start_btn, stop_btn, clear_btn, dir_btn, load_max, mode, max_in, count,
        input  cnt_pause, cnt_direction, cnt_maximum, cnt_rst, state
    );
endinterface

// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Turns button edges into a run/pause/clear FSM for the 8-bit up/down wrap
//   counter, prescales the system clock into count steps via cnt_pause, holds
//   the counter maximum and direction, and optionally bounces between 0 and
//   the maximum.
//   Ports:
//     clk : system clock, rising edge
//     rst : asynchronous active-low reset
//     bus : counter_sequencer_if.master (buttons, mode, max_in, count in;
//           cnt_pause, cnt_direction, cnt_maximum, cnt_rst, state out)
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | stopped after reset or clear; maximum may be loaded
//   RUN    | prescaler running, counter steps every TICK_DIV cycles
//   PAUSED | stopped mid-count; maximum may be loaded
//   CLEAR  | one-cycle cnt_rst pulse, then IDLE; events discarded
module counter_sequencer #(
    parameter int TICK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    counter_sequencer_if.master   bus
);
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] RUN    = 2'b01;
    localparam logic [1:0] PAUSED = 2'b10;
    localparam logic [1:0] CLEAR  = 2'b11;

    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [4:0]  btn;
    logic [4:0]  btn_q;
    logic [4:0]  ev;
    logic        ev_start;
    logic        ev_stop;
    logic        ev_clear;
    logic        ev_dir;
    logic        ev_load;
    logic [15:0] div_q;
    logic        dir_q;
    logic [7:0]  max_q;
    logic        tick;

    // Bit order: {load, dir, clear, stop, start}
    assign btn      = {bus.load_max, bus.dir_btn, bus.clear_btn, bus.stop_btn, bus.start_btn};
    assign ev       = btn & ~btn_q;
    assign ev_start = ev[0];
    assign ev_stop  = ev[1];
    assign ev_clear = ev[2];
    assign ev_dir   = ev[3];
    assign ev_load  = ev[4];

    assign tick = (state_q == RUN) && (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ev_clear)
                    state_d = CLEAR;
                else if (ev_start)
                    state_d = RUN;
            end
            RUN: begin
                if (ev_clear)
                    state_d = CLEAR;
                else if (ev_stop)
                    state_d = PAUSED;
            end
            PAUSED: begin
                // A new maximum below the current count would let an up-count
                // run past it, so such a load also clears the counter.
                if (ev_clear || (ev_load && (bus.max_in < bus.count)))
                    state_d = CLEAR;
                else if (ev_start)
                    state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            btn_q   <= 5'b00000;
            div_q   <= 16'd0;
            dir_q   <= 1'b1;
            max_q   <= 8'hFF;
        end else begin
            state_q <= state_d;
            btn_q   <= btn;

            // Prescaler only advances while staying in RUN; any entry into RUN
            // starts from 0 so the first step lands TICK_DIV cycles later.
            if ((state_q == RUN) && (state_d == RUN))
                div_q <= tick ? 16'd0 : div_q + 16'd1;
            else
                div_q <= 16'd0;

            // Bounce endpoints override a manual toggle; zero wins over max
            // so a maximum of 0 still counts up.
            if (bus.mode && (bus.count == 8'd0))
                dir_q <= 1'b1;
            else if (bus.mode && (bus.count == max_q))
                dir_q <= 1'b0;
            else if (ev_dir && (state_q != CLEAR))
                dir_q <= ~dir_q;

            if (ev_load && ((state_q == IDLE) || (state_q == PAUSED)))
                max_q <= bus.max_in;
        end
    end

    assign bus.cnt_pause     = ~tick;
    assign bus.cnt_direction = dir_q;
    assign bus.cnt_maximum   = max_q;
    assign bus.cnt_rst       = (state_q == CLEAR);
    assign bus.state         = state_q;
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer
//   Drives counter_sequencer with directed scenarios followed by random button
//   activity. A behavioural counter closes the loop on count, and a reference
//   model tracks the expected sequencer outputs from the button rules.
module tb_counter_sequencer;
    localparam int TICK_DIV = 4;

    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_PAUSED = 2;
    localparam int S_CLEAR  = 3;

    localparam int B_START = 0;
    localparam int B_STOP  = 1;
    localparam int B_CLEAR = 2;
    localparam int B_DIR   = 3;
    localparam int B_LOAD  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn_drv;
    int         n_assert = 0;
    int         n_fail   = 0;

    counter_sequencer_if ifc();

    counter_sequencer #(.TICK_DIV(TICK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    assign ifc.start_btn = btn_drv[B_START];
    assign ifc.stop_btn  = btn_drv[B_STOP];
    assign ifc.clear_btn = btn_drv[B_CLEAR];
    assign ifc.dir_btn   = btn_drv[B_DIR];
    assign ifc.load_max  = btn_drv[B_LOAD];

    // The 8-bit up/down wrap counter the sequencer controls.
    always @(posedge clk or negedge rst) begin
        if (!rst)
            ifc.count <= 8'd0;
        else if (ifc.cnt_rst)
            ifc.count <= 8'd0;
        else if (!ifc.cnt_pause) begin
            if (ifc.cnt_direction)
                ifc.count <= (ifc.count == ifc.cnt_maximum) ? 8'd0 : ifc.count + 8'd1;
            else
                ifc.count <= (ifc.count == 8'd0) ? ifc.cnt_maximum : ifc.count - 8'd1;
        end
    end

    // Reference model: state, cycles spent in the current RUN stretch,
    // direction and maximum.
    int         m_state;
    int         m_run;
    logic [4:0] m_prev;
    logic       m_dir;
    logic [7:0] m_max;
    logic [4:0] m_ev;

    assign m_ev = btn_drv & ~m_prev;

    function automatic int next_of(int s, logic [4:0] e, logic lower);
        if (s == S_IDLE)   return e[B_CLEAR] ? S_CLEAR : (e[B_START] ? S_RUN : S_IDLE);
        if (s == S_RUN)    return e[B_CLEAR] ? S_CLEAR : (e[B_STOP] ? S_PAUSED : S_RUN);
        if (s == S_PAUSED) begin
            if (e[B_CLEAR] || (e[B_LOAD] && lower)) return S_CLEAR;
            return e[B_START] ? S_RUN : S_PAUSED;
        end
        return S_IDLE;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state <= S_IDLE;
            m_run   <= 0;
            m_prev  <= 5'b0;
            m_dir   <= 1'b1;
            m_max   <= 8'hFF;
        end else begin
            m_prev  <= btn_drv;
            m_state <= next_of(m_state, m_ev, ifc.max_in < ifc.count);
            m_run   <= (m_state == S_RUN && next_of(m_state, m_ev, ifc.max_in < ifc.count) == S_RUN)
                       ? m_run + 1 : 0;
            if (ifc.mode && ifc.count == 8'd0)
                m_dir <= 1'b1;
            else if (ifc.mode && ifc.count == m_max)
                m_dir <= 1'b0;
            else if (m_ev[B_DIR] && m_state != S_CLEAR)
                m_dir <= !m_dir;
            if (m_ev[B_LOAD] && (m_state == S_IDLE || m_state == S_PAUSED))
                m_max <= ifc.max_in;
        end
    end

    function automatic logic exp_pause();
        return !(m_state == S_RUN && (m_run % TICK_DIV) == TICK_DIV - 1);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("state", 32'(ifc.state), m_state);
        chk("pause", 32'(ifc.cnt_pause), 32'(exp_pause()));
        chk("direction", 32'(ifc.cnt_direction), 32'(m_dir));
        chk("maximum", 32'(ifc.cnt_maximum), 32'(m_max));
        chk("cnt_rst", 32'(ifc.cnt_rst), 32'(m_state == S_CLEAR));
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check_all();
        end
    endtask

    task automatic press(int b);
        btn_drv[b] = 1'b1;
        cyc(1);
        btn_drv[b] = 1'b0;
    endtask

    initial begin
        byte unsigned exp1[6];
        byte unsigned exp2[7];
        logic [7:0]   last;
        int           idx;
        int           raise;

        exp1 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
        exp2 = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1};

        rst        = 1'b0;
        btn_drv    = 5'b0;
        ifc.mode   = 1'b0;
        ifc.max_in = 8'd0;
        cyc(3);
        chk("reset_state", 32'(ifc.state), 32'(S_IDLE));
        chk("reset_max", 32'(ifc.cnt_maximum), 32'hFF);
        chk("reset_pause", 32'(ifc.cnt_pause), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Wrap run: max 5, one step every TICK_DIV cycles
        ifc.max_in = 8'd5;
        press(B_LOAD);
        chk("t1_max", 32'(ifc.cnt_maximum), 32'd5);
        press(B_START);
        chk("t1_run", 32'(ifc.state), 32'(S_RUN));
        last = ifc.count;
        idx  = 0;
        for (int c = 1; c <= 40 && idx < 6; c++) begin
            cyc(1);
            if (ifc.count !== last) begin
                chk("t1_value", 32'(ifc.count), 32'(exp1[idx]));
                chk("t1_time", c, 4 * (idx + 1));
                idx++;
                last = ifc.count;
            end
        end
        chk("t1_steps", idx, 6);

        // Bounce run: max 3, with a dir pulse while parked at the top
        press(B_CLEAR);
        chk("t2_clear_pulse", 32'(ifc.cnt_rst), 32'd1);
        cyc(1);
        chk("t2_idle", 32'(ifc.state), 32'(S_IDLE));
        chk("t2_count0", 32'(ifc.count), 32'd0);
        ifc.mode   = 1'b1;
        ifc.max_in = 8'd3;
        press(B_LOAD);
        press(B_START);
        last  = ifc.count;
        idx   = 0;
        raise = 0;
        for (int c = 1; c <= 48 && idx < 7; c++) begin
            if (raise == 1) raise = 2;
            else if (raise == 2) begin btn_drv[B_DIR] = 1'b1; raise = 3; end
            else if (raise == 3) begin btn_drv[B_DIR] = 1'b0; raise = 4; end
            cyc(1);
            if (ifc.count !== last) begin
                chk("t2_value", 32'(ifc.count), 32'(exp2[idx]));
                chk("t2_time", c, 4 * (idx + 1));
                if (ifc.count == 8'd3 && raise == 0) raise = 1;
                idx++;
                last = ifc.count;
            end
        end
        chk("t2_steps", idx, 7);
        btn_drv[B_DIR] = 1'b0;

        // Run to 200, stop, load a lower maximum -> forced clear
        ifc.mode = 1'b0;
        press(B_STOP);
        chk("t3_paused", 32'(ifc.state), 32'(S_PAUSED));
        ifc.max_in = 8'hFF;
        press(B_LOAD);
        chk("t3_no_clear", 32'(ifc.state), 32'(S_PAUSED));
        press(B_START);
        for (int c = 0; c < 1200 && ifc.count != 8'd200; c++) cyc(1);
        chk("t3_reach200", 32'(ifc.count), 32'd200);
        press(B_STOP);
        chk("t3_stop", 32'(ifc.state), 32'(S_PAUSED));
        chk("t3_hold200", 32'(ifc.count), 32'd200);
        ifc.max_in = 8'd50;
        press(B_LOAD);
        chk("t3_clear_state", 32'(ifc.state), 32'(S_CLEAR));
        chk("t3_cnt_rst", 32'(ifc.cnt_rst), 32'd1);
        cyc(1);
        chk("t3_idle", 32'(ifc.state), 32'(S_IDLE));
        chk("t3_count0", 32'(ifc.count), 32'd0);
        chk("t3_max50", 32'(ifc.cnt_maximum), 32'd50);
        chk("t3_rst_low", 32'(ifc.cnt_rst), 32'd0);

        // Stop, start and clear together in RUN -> clear wins
        press(B_START);
        cyc(5);
        btn_drv[B_START] = 1'b1;
        btn_drv[B_STOP]  = 1'b1;
        btn_drv[B_CLEAR] = 1'b1;
        cyc(1);
        btn_drv = 5'b0;
        chk("t4_clear", 32'(ifc.state), 32'(S_CLEAR));
        chk("t4_cnt_rst", 32'(ifc.cnt_rst), 32'd1);
        cyc(1);
        chk("t4_idle", 32'(ifc.state), 32'(S_IDLE));
        chk("t4_cnt_rst_off", 32'(ifc.cnt_rst), 32'd0);

        // Held start: one RUN entry, stop pauses with no restart
        btn_drv[B_START] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("t5_run", 32'(ifc.state), 32'(S_RUN));
        end
        press(B_STOP);
        for (int i = 0; i < 6; i++) begin
            chk("t5_paused", 32'(ifc.state), 32'(S_PAUSED));
            cyc(1);
        end
        btn_drv[B_START] = 1'b0;
        cyc(1);

        // Asynchronous reset mid-RUN between ticks
        press(B_START);
        cyc(2);
        chk("t6_running", 32'(ifc.state), 32'(S_RUN));
        rst = 1'b0;
        #1;
        check_all();
        chk("t6_state", 32'(ifc.state), 32'(S_IDLE));
        chk("t6_pause", 32'(ifc.cnt_pause), 32'd1);
        chk("t6_dir", 32'(ifc.cnt_direction), 32'd1);
        chk("t6_max", 32'(ifc.cnt_maximum), 32'hFF);
        chk("t6_cnt_rst", 32'(ifc.cnt_rst), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        last = ifc.count;
        cyc(12);
        chk("t6_no_step", 32'(ifc.count), 32'(last));
        chk("t6_idle", 32'(ifc.state), 32'(S_IDLE));

        // Random button activity against the model
        for (int i = 0; i < 600; i++) begin
            btn_drv = 5'($urandom) & 5'($urandom);
            if ($urandom_range(0, 31) == 0) ifc.mode = ~ifc.mode;
            ifc.max_in = 8'($urandom);
            cyc(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
